// File: rtl/alien_fleet.sv
// Alien invader fleet: 4x8 grid that marches across the playfield, drops a row at
// each edge, and loses aliens to the player bullet.
module alien_fleet #(
   parameter int unsigned STEP_TICKS = 8,
   parameter int unsigned LAND_ROW   = 14
) (
   input  logic        clk_36MHz,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [4:0]  bullet_x,
   input  logic [3:0]  bullet_y,
   input  logic        bullet_flying,
   output logic        hit,
   output logic [31:0] alive,
   output logic [4:0]  fleet_x,
   output logic [3:0]  fleet_y,
   output logic        fleet_dir,
   output logic        all_dead,
   output logic        landed
);

   typedef enum logic {MARCH = 1'b0, HALTED = 1'b1} state_t;

   localparam logic [7:0] LAST_TICK  = 8'(STEP_TICKS - 1);
   localparam logic [4:0] LAND_ROW_5 = 5'(LAND_ROW);
   localparam logic [4:0] RIGHT_EDGE = 5'd24;

   state_t      state;
   state_t      state_next;
   logic [7:0]  tick_cnt;
   logic        hit_lock;
   logic        marching;
   logic        step;
   logic        rearm;
   logic [4:0]  dx;
   logic [3:0]  dy;
   logic [4:0]  hit_idx;
   logic        candidate;
   logic        do_hit;

   assign rearm = !reset || clear;

   always_ff @(posedge clk_36MHz) begin
      if (rearm)
         state <= MARCH;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         MARCH:   if (all_dead || landed) state_next = HALTED;
         HALTED:  state_next = HALTED;
         default: state_next = MARCH;
      endcase
   end

   always_comb begin
      marching = (state == MARCH);
      step     = marching && enable && (tick_cnt == LAST_TICK);
   end

   // Bullet is compared against the current (pre-step) origin, so a hit that lands
   // on a step edge clears the cell the player actually saw.
   always_comb begin
      dx        = bullet_x - fleet_x;
      dy        = bullet_y - fleet_y;
      hit_idx   = {dy[1:0], dx[2:0]};
      candidate = bullet_flying && (bullet_x >= fleet_x) && (dx < 5'd8) &&
                  (bullet_y >= fleet_y) && (dy < 4'd4) && alive[hit_idx];
      do_hit    = candidate && !hit_lock;
   end

   always_ff @(posedge clk_36MHz) begin
      if (rearm) begin
         tick_cnt  <= '0;
         fleet_x   <= '0;
         fleet_y   <= '0;
         fleet_dir <= 1'b1;
         alive     <= '1;
         hit       <= 1'b0;
         hit_lock  <= 1'b0;
         all_dead  <= 1'b0;
         landed    <= 1'b0;
      end else begin
         if (marching && enable)
            tick_cnt <= (tick_cnt == LAST_TICK) ? 8'd0 : tick_cnt + 8'd1;

         if (step) begin
            if (fleet_dir && fleet_x < RIGHT_EDGE)
               fleet_x <= fleet_x + 5'd1;
            else if (!fleet_dir && fleet_x != 5'd0)
               fleet_x <= fleet_x - 5'd1;
            else begin
               fleet_y   <= fleet_y + 4'd1;
               fleet_dir <= !fleet_dir;
            end
         end

         // The lock keeps one bullet from chewing through a column of aliens.
         hit <= do_hit;
         if (do_hit) begin
            alive[hit_idx] <= 1'b0;
            hit_lock       <= 1'b1;
         end else if (!bullet_flying) begin
            hit_lock <= 1'b0;
         end

         all_dead <= (alive == 32'd0);
         landed   <= (({1'b0, fleet_y} + 5'd3) >= LAND_ROW_5);
      end
   end

endmodule
